// File: rtl/if_else_parser.sv
// Streaming recogniser for "if(x<cmp><val>)begin p<=<c1>;end else begin p<=<c2>;end", one char per char_valid rising edge.
// p/parsing_done/error_flag update on the edge that consumes the deciding char; no backpressure, DONE and ERR are sticky.
module if_else_parser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [6:0]        ascii_char,
  input  logic              char_valid,
  output logic [DATA_W-1:0] p,
  output logic              parsing_done,
  output logic              error_flag
);

  typedef enum logic [3:0] {
    EXPECT_I, CMP1, CMP2, VAL, MID1, C1, MID2, C2, TAIL, DONE, ERR
  } state_t;

  typedef enum logic [2:0] {OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE} op_t;

  localparam logic [6:0] CH_EQ   = 7'h3D;
  localparam logic [6:0] CH_BANG = 7'h21;
  localparam logic [6:0] CH_LT   = 7'h3C;
  localparam logic [6:0] CH_GT   = 7'h3E;
  localparam logic [6:0] CH_RP   = 7'h29;
  localparam logic [6:0] CH_SEMI = 7'h3B;

  // Fixed keyword runs, left-aligned and space padded to 16 chars so any 4-bit index is in range.
  localparam logic [127:0] KW_HEAD = {"if(x", {12{8'h20}}};
  localparam logic [127:0] KW_MID1 = {"beginp<=", {8{8'h20}}};
  localparam logic [127:0] KW_MID2 = {"endelsebeginp<=", 8'h20};
  localparam logic [127:0] KW_TAIL = {"end", {13{8'h20}}};

  function automatic logic [6:0] kw_char(input state_t s, input logic [3:0] i);
    logic [6:0] c;
    c = 7'h00;
    case (s)
      EXPECT_I: c = KW_HEAD[{~i, 3'b000} +: 7];
      MID1:     c = KW_MID1[{~i, 3'b000} +: 7];
      MID2:     c = KW_MID2[{~i, 3'b000} +: 7];
      TAIL:     c = KW_TAIL[{~i, 3'b000} +: 7];
      default:  c = 7'h00;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] kw_last(input state_t s);
    logic [3:0] n;
    case (s)
      EXPECT_I: n = 4'd3;
      MID1:     n = 4'd7;
      MID2:     n = 4'd14;
      default:  n = 4'd2;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] mac10(input logic [DATA_W-1:0] a, input logic [3:0] d);
    return {a[DATA_W-4:0], 3'b000} + {a[DATA_W-2:0], 1'b0} + DATA_W'(d);
  endfunction

  state_t            state, state_n;
  op_t               op, op_n;
  logic [3:0]        idx, idx_n;
  logic [DATA_W-1:0] acc, acc_n, c1, c1_n, p_n;
  logic              cond, cond_n, seen, seen_n, done_n, err_n, prev_valid, go_err;
  logic              take, is_ws, is_digit, cmp_res;

  assign take     = char_valid & ~prev_valid;
  assign is_ws    = (ascii_char == 7'h20) || (ascii_char == 7'h09) ||
                    (ascii_char == 7'h0A) || (ascii_char == 7'h0D);
  assign is_digit = (ascii_char >= 7'h30) && (ascii_char <= 7'h39);

  always_comb begin
    case (op)
      OP_EQ:   cmp_res = (x == acc);
      OP_NE:   cmp_res = (x != acc);
      OP_LT:   cmp_res = (x <  acc);
      OP_GT:   cmp_res = (x >  acc);
      OP_LE:   cmp_res = (x <= acc);
      OP_GE:   cmp_res = (x >= acc);
      default: cmp_res = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    idx_n   = idx;
    acc_n   = acc;
    c1_n    = c1;
    cond_n  = cond;
    seen_n  = seen;
    p_n     = p;
    done_n  = parsing_done;
    err_n   = error_flag;
    go_err  = 1'b0;
    if (take && !is_ws) begin
      case (state)
        EXPECT_I, MID1, MID2, TAIL: begin
          if (ascii_char != kw_char(state, idx)) begin
            go_err = 1'b1;
          end else if (idx != kw_last(state)) begin
            idx_n = idx + 4'd1;
          end else begin
            idx_n  = '0;
            seen_n = 1'b0;
            case (state)
              EXPECT_I: state_n = CMP1;
              MID1:     state_n = C1;
              MID2:     state_n = C2;
              default: begin
                state_n = DONE;
                done_n  = 1'b1;
                p_n     = cond ? c1 : acc;
              end
            endcase
          end
        end
        CMP1: begin
          state_n = CMP2;
          case (ascii_char)
            CH_EQ:   op_n = OP_EQ;
            CH_BANG: op_n = OP_NE;
            CH_LT:   op_n = OP_LT;
            CH_GT:   op_n = OP_GT;
            default: go_err = 1'b1;
          endcase
        end
        CMP2: begin
          if (ascii_char == CH_EQ) begin
            state_n = VAL;
            seen_n  = 1'b0;
            if (op == OP_LT) op_n = OP_LE;
            else if (op == OP_GT) op_n = OP_GE;
          end else if (is_digit && (op == OP_LT || op == OP_GT)) begin
            // A digit right after '<' or '>' is both the strict operator and the first value digit.
            state_n = VAL;
            seen_n  = 1'b1;
            acc_n   = mac10(acc, ascii_char[3:0]);
          end else begin
            go_err = 1'b1;
          end
        end
        VAL, C1, C2: begin
          if (is_digit) begin
            acc_n  = mac10(acc, ascii_char[3:0]);
            seen_n = 1'b1;
          end else if (seen && state == VAL && ascii_char == CH_RP) begin
            cond_n  = cmp_res;
            acc_n   = '0;
            state_n = MID1;
          end else if (seen && state == C1 && ascii_char == CH_SEMI) begin
            c1_n    = acc;
            acc_n   = '0;
            state_n = MID2;
          end else if (seen && state == C2 && ascii_char == CH_SEMI) begin
            state_n = TAIL;
          end else begin
            go_err = 1'b1;
          end
        end
        default: ;
      endcase
      if (go_err) begin
        state_n = ERR;
        err_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EXPECT_I;
      op           <= OP_EQ;
      idx          <= '0;
      acc          <= '0;
      c1           <= '0;
      cond         <= 1'b0;
      seen         <= 1'b0;
      prev_valid   <= 1'b0;
      p            <= '0;
      parsing_done <= 1'b0;
      error_flag   <= 1'b0;
    end else begin
      state        <= state_n;
      op           <= op_n;
      idx          <= idx_n;
      acc          <= acc_n;
      c1           <= c1_n;
      cond         <= cond_n;
      seen         <= seen_n;
      prev_valid   <= char_valid;
      p            <= p_n;
      parsing_done <= done_n;
      error_flag   <= err_n;
    end
  end

endmodule

// File: tb/tb_if_else_parser.sv
// Directed-vector bench for if_else_parser: operators, wrap, whitespace, errors, pulse handling and reset.
module tb_if_else_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] x = '0;
  logic [6:0]  ascii_char = '0;
  logic        char_valid = 1'b0;
  logic [31:0] p;
  logic        parsing_done;
  logic        error_flag;

  int n_checks = 0;
  int n_fail   = 0;

  if_else_parser #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .ascii_char   (ascii_char),
    .char_valid   (char_valid),
    .p            (p),
    .parsing_done (parsing_done),
    .error_flag   (error_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] ep, input logic ed, input logic ee);
    check({tag, ".p"}, p, ep);
    check({tag, ".done"}, 32'(parsing_done), 32'(ed));
    check({tag, ".err"}, 32'(error_flag), 32'(ee));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_char(input byte c, input int hold, input int gap);
    ascii_char = c[6:0];
    char_valid = 1'b1;
    repeat (hold) @(negedge clk);
    char_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int hold, input int gap);
    for (int i = 0; i < s.len(); i++) send_char(s[i], hold, gap);
  endtask

  // Sends all but the last char, checks nothing is committed, then checks the edge that takes the last char.
  task automatic run_stream(input string tag, input string s, input int hold, input int gap,
                            input logic [31:0] exp_p);
    byte b;
    send_str(s.substr(0, s.len() - 2), hold, gap);
    check_out({tag, ".pre"}, 32'd0, 1'b0, 1'b0);
    b = s[s.len() - 1];
    ascii_char = b[6:0];
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out({tag, ".end"}, exp_p, 1'b1, 1'b0);
    @(negedge clk);
    repeat (hold - 1) @(negedge clk);
    char_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic string mk(input string cmp, input string val);
    return {"if(x", cmp, val, ")begin p<=20;endelsebegin p<=30;end"};
  endfunction

  initial begin
    string s;
    #1;
    check_out("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);

    do_reset(); x = 32'd6;
    run_stream("gt_x6", mk(">", "5"), 2, 1, 32'd20);
    send_str("if(x>5)", 1, 1);
    check_out("done_sticky", 32'd20, 1'b1, 1'b0);

    do_reset(); x = 32'd5;
    run_stream("gt_x5", mk(">", "5"), 2, 1, 32'd30);
    do_reset(); run_stream("ge_x5", mk(">=", "5"), 2, 1, 32'd20);
    do_reset(); run_stream("ne_x5", mk("!=", "5"), 2, 1, 32'd30);
    do_reset(); run_stream("eq_x5", mk("==", "5"), 2, 1, 32'd20);
    do_reset(); run_stream("lt_x5", mk("<", "5"), 1, 1, 32'd30);
    do_reset(); run_stream("le_x5", mk("<=", "5"), 1, 1, 32'd20);

    do_reset(); x = 32'd123;
    run_stream("ws_num", mk("==", "12 3"), 1, 1, 32'd20);

    s = "if(x<4000000000)begin p<=7;end else begin p<=4294967297;end";
    do_reset(); x = 32'd3;
    run_stream("big_true", s, 1, 1, 32'd7);
    do_reset(); x = 32'd4000000001;
    run_stream("big_wrap", s, 1, 1, 32'd1);

    do_reset();
    send_str("if(x=", 1, 1);
    check_out("eq_digit.pre", 32'd0, 1'b0, 1'b0);
    send_char("5", 1, 1);
    check_out("eq_digit", 32'd0, 1'b0, 1'b1);
    send_str(")begin p<=1;end", 1, 1);
    check_out("eq_digit.after", 32'd0, 1'b0, 1'b1);

    do_reset();
    send_str("if(x>", 1, 1);
    check_out("empty_val.pre", 32'd0, 1'b0, 1'b0);
    send_char(")", 1, 1);
    check_out("empty_val", 32'd0, 1'b0, 1'b1);

    do_reset();
    send_char("i", 1, 1);
    check_out("ig.pre", 32'd0, 1'b0, 1'b0);
    send_char("g", 1, 1);
    check_out("ig", 32'd0, 1'b0, 1'b1);
    send_str("f(x>5)begin", 1, 1);
    check_out("ig.after", 32'd0, 1'b0, 1'b1);

    do_reset(); x = 32'd6;
    s = mk(">", "5");
    send_char("i", 5, 1);
    run_stream("hold5", s.substr(1, s.len() - 1), 1, 1, 32'd20);

    do_reset(); x = 32'd6;
    send_str(s.substr(0, 6), 1, 1);
    x = 32'd0;
    run_stream("x_late", s.substr(7, s.len() - 1), 1, 1, 32'd20);

    #2 rst = 1'b0;
    #1 check_out("async_rst", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    x = 32'd6;
    send_str("if(x>5)begin", 1, 1);
    #2 rst = 1'b0;
    #1 check_out("mid_rst", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_stream("after_rst", s, 1, 1, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_else_parser.md
Name: if_else_parser

Overview:
Streaming character-level recogniser for one fixed-form conditional statement, `if(x<cmp><val>)begin p<=<c1>;end else begin p<=<c2>;end`, received one 7-bit ASCII character per `char_valid` pulse. It evaluates the condition against the live input `x` and drives `p` with the selected constant. It flags completion or a syntax error. It sits between a character source (UART or host stub) and logic consuming `p`.

Parameters:
- DATA_W, 32, width of `x`, `p` and all parsed constants (arithmetic wraps modulo 2^DATA_W).

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- x  in  DATA_W  operand compared against `<val>`; unsigned.
- ascii_char  in  7  character code, qualified by `char_valid`.
- char_valid  in  1  character strobe; level may be held for several cycles.
- p  out  DATA_W  result register.
- parsing_done  out  1  complete statement accepted without error.
- error_flag  out  1  syntax error detected.

Behaviour:
- Reset (rst=0, async): state=EXPECT_I, p=0, parsing_done=0, error_flag=0, accumulators=0, cond=0, char_valid history=0.
- Acceptance:
  - A character is consumed only on a rising clock edge where `char_valid`=1 and the registered previous `char_valid`=0.
  - Holding `char_valid` high for N cycles consumes exactly one character.
  - One character is consumed per clock at most.
- Whitespace (0x20, 0x09, 0x0A, 0x0D) is consumed and ignored in every state. It also terminates nothing: "12 3" parses as 123.
- Grammar, in order, with one state or keyword index per position:
  1. `i`, `f`, `(`, `x`.
  2. CMP1 accepts `=`, `!`, `<`, or `>`.
  3. CMP2:
     - `=` forms `==`, `!=`, `<=`, or `>=`.
     - A digit after `<` or `>` means strict `<` or `>`; that digit is also the first digit of `val`.
     - A digit after `=` or `!` is an error.
  4. VAL: one or more digits. Accumulate `acc = acc*10 + digit` (mod 2^DATA_W). `)` terminates it.
  5. `begin`, `p`, `<`, `=`.
  6. C1: one or more digits, terminated by `;`.
  7. `end`, `else`, `begin`, `p`, `<`, `=`.
  8. C2: one or more digits, terminated by `;`.
  9. `end` leads to DONE.
- Condition:
  - Evaluated as unsigned on the clock the `)` is consumed, using `x` at that edge.
  - The result is latched in `cond`; later changes to `x` are ignored.
- Completion:
  - On consuming the final `d`, at the same edge: p <= cond ? C1 : C2, and parsing_done <= 1.
  - `p` therefore changes exactly once per parse. It holds 0 until then.
- Errors:
  - Any non-whitespace character not permitted in the current state sets error_flag=1 at that edge and enters ERR.
  - An empty number (non-digit where the first digit is required) is an error.
- ERR and DONE are sticky until reset. Further characters are ignored; `p`, `parsing_done` and `error_flag` hold. `parsing_done` and `error_flag` are never both 1.
- Reset mid-parse aborts immediately to the reset values above.

Test Plan:
- x=6, stream `if(x>5)begin p<=20;endelsebegin p<=30;end`, each `char_valid` held 2 cycles then 1 low → parsing_done=1 and error_flag=0 within 1 cycle of the last `d`; p=20; p=0 before the last `d`.
- Same stream with x=5 → p=30; with `>=` and x=5 → p=20; with `!=` and x=5 → p=30; with `==` and x=5 → p=20.
- x=3, `if(x<4000000000)begin p<=7;end else begin p<=4294967297;end` → p=7. With x=4000000001 → p=1, showing the C2 wrap mod 2^32.
- Stream `if(x=5)...` → error_flag=1 at the `5`. `if(x>)` → error at `)`. `ig` → error at `g`. In every case parsing_done=0, p=0, and subsequent chars leave the outputs unchanged.
- Hold `char_valid` high 5 cycles on `i`, then send `f(...` normally → parse succeeds, proving a single consumption per pulse. Back-to-back 1-cycle pulses separated by 1 low cycle also parse correctly.
- Deassert rst mid-stream after `begin` → outputs return to 0 asynchronously. A fresh full stream after release parses correctly. Changing x after `)` does not alter the selected p.
